// File: rtl/lc3b_mem_pkg.sv
// Shared types and constants for the LC-3b memory arbiter.
package lc3b_mem_pkg;

    // Arbiter FSM states; the encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    // Owner of the access currently in flight (also used as last-grant tag).
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    // Byte-enable patterns for the 16-bit memory word.
    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_NONE = 2'b00;

    // Cycles from grant to completion pulse (legal range 2..15).
    localparam int DEFAULT_LATENCY = 5;

    // Width of the access down-counter; holds LATENCY-1 up to 14.
    localparam int CNT_W = 4;

    // Byte-lane enable for a byte access at the given address LSB.
    function automatic logic [1:0] byte_be(input logic addr_lsb);
        return addr_lsb ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: bit 0 is the CPU, bit 1 is the DMA engine.
// When both request, the one that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_dma_i,
    output logic [1:0] gnt_o
);

    // One-hot grant; a lone requester always wins, a tie goes to the other side.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_dma_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between the LC-3b CPU and a DMA engine.
//
// Handshake (both requesters): the requester raises *_req with its command
// fields and keeps them up until it sees its one-cycle completion pulse
// (cpu_r / dma_ack). The command is latched on the grant edge, so later
// changes, including dropping the request, do not affect the access in flight.
// The pulse coincides with the last ACCESS cycle; the following RECOVER
// cycle grants nothing, which gives the requester one cycle to drop *_req
// without the same access being issued again.
module mem_arbiter
    import lc3b_mem_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_size,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_r,
    output logic [15:0] cpu_rdata,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic [15:0] dma_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    input  logic [15:0] mem_rdata,

    output logic [1:0]  dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state_q;
    owner_t            owner_q;
    owner_t            last_q;
    logic              we_q;
    logic              size_q;
    logic [15:0]       addr_q;
    logic [15:0]       wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cpu_r_q;
    logic              dma_ack_q;
    logic [15:0]       cpu_rdata_q;
    logic [15:0]       dma_rdata_q;

    logic [1:0]        gnt;
    logic              in_access;

    rr_arb2 u_rr (
        .req_i      ({dma_req, cpu_req}),
        .last_dma_i (last_q == OWN_DMA),
        .gnt_o      (gnt)
    );

    // Arbiter FSM: grant in IDLE, count down in ACCESS, one dead cycle in RECOVER.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_DMA;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_r_q     <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            cpu_r_q   <= 1'b0;
            dma_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt != 2'b00) begin
                        state_q <= ST_ACCESS;
                        cnt_q   <= CNT_LOAD;
                        if (gnt[1]) begin
                            owner_q <= OWN_DMA;
                            last_q  <= OWN_DMA;
                            we_q    <= dma_we;
                            size_q  <= 1'b1;
                            addr_q  <= dma_addr;
                            wdata_q <= dma_wdata;
                        end else begin
                            owner_q <= OWN_CPU;
                            last_q  <= OWN_CPU;
                            we_q    <= cpu_we;
                            size_q  <= cpu_size;
                            addr_q  <= cpu_addr;
                            wdata_q <= cpu_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                    // Counter reaches 0 next cycle: raise the pulse so it
                    // lines up with the final ACCESS cycle.
                    if (cnt_q == CNT_W'(1)) begin
                        cpu_r_q   <= (owner_q == OWN_CPU);
                        dma_ack_q <= (owner_q == OWN_DMA);
                    end
                    if (cnt_q == '0) begin
                        state_q <= ST_RECOVER;
                        if (!we_q) begin
                            if (owner_q == OWN_DMA) begin
                                dma_rdata_q <= mem_rdata;
                            end else begin
                                cpu_rdata_q <= mem_rdata;
                            end
                        end
                    end
                end
                ST_RECOVER: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_access = (state_q == ST_ACCESS);

    // Memory port decode from the latched command; everything is zero outside ACCESS.
    always_comb begin
        mem_be    = BE_NONE;
        mem_wdata = '0;
        mem_addr  = '0;
        if (in_access) begin
            mem_addr = addr_q[15:1];
            if (size_q) begin
                mem_be    = BE_WORD;
                mem_wdata = wdata_q;
            end else begin
                mem_be    = byte_be(addr_q[0]);
                mem_wdata = {wdata_q[7:0], wdata_q[7:0]};
            end
        end
    end

    assign mem_en    = in_access;
    assign mem_we    = in_access & we_q;
    assign cpu_r     = cpu_r_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single accesses plus
// hand-written sequences for round-robin, reset abort and request hold.
module tb_mem_arbiter;
    import lc3b_mem_pkg::*;

    localparam int LAT = 5;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_size;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_r;
    logic        dma_req, dma_we;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ack;
    logic        mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [1:0]  mem_be;
    logic [1:0]  dbg_state;

    mem_arbiter #(.LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_size  (cpu_size),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_r     (cpu_r),
        .cpu_rdata (cpu_rdata),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_dma;
        logic        we;
        logic        size;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic [14:0] exp_addr;
        logic [1:0]  exp_be;
        logic [15:0] exp_wdata;
    } vec_t;

    vec_t        vecs[8];
    int          n_cmp;
    int          n_fail;
    logic [15:0] exp_cpu_rd;
    logic [15:0] exp_dma_rd;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
        end
    endtask

    task automatic chk_st(input string name, input state_t exp);
        chk_w(name, {14'b0, dbg_state}, {14'b0, 2'(exp)});
    endtask

    task automatic do_reset();
        cpu_req = 0; cpu_we = 0; cpu_size = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        mem_rdata = 16'hDEAD;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        exp_cpu_rd = '0;
        exp_dma_rd = '0;
    endtask

    // One uncontended access; inputs are scrambled and the request dropped
    // right after the grant, so the access must run on latched values.
    task automatic run_access(input vec_t v, input int idx);
        logic pulse;
        if (v.is_dma) begin
            dma_req = 1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
        end else begin
            cpu_req = 1; cpu_we = v.we; cpu_size = v.size;
            cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        @(posedge clk); #1;
        for (int k = 1; k <= LAT; k++) begin
            pulse = v.is_dma ? dma_ack : cpu_r;
            chk_b($sformatf("v%0d c%0d mem_en", idx, k), mem_en, 1'b1);
            chk_b($sformatf("v%0d c%0d mem_we", idx, k), mem_we, v.we);
            chk_w($sformatf("v%0d c%0d mem_addr", idx, k), {1'b0, mem_addr}, {1'b0, v.exp_addr});
            chk_w($sformatf("v%0d c%0d mem_be", idx, k), {14'b0, mem_be}, {14'b0, v.exp_be});
            chk_w($sformatf("v%0d c%0d mem_wdata", idx, k), mem_wdata, v.exp_wdata);
            chk_b($sformatf("v%0d c%0d done_pulse", idx, k), pulse, (k == LAT));
            if (k == 1) begin
                chk_st($sformatf("v%0d state_access", idx), ST_ACCESS);
                if (v.is_dma) begin
                    dma_req = 0; dma_we = ~v.we; dma_addr = ~v.addr; dma_wdata = ~v.wdata;
                end else begin
                    cpu_req = 0; cpu_we = ~v.we; cpu_size = ~v.size;
                    cpu_addr = ~v.addr; cpu_wdata = ~v.wdata;
                end
            end
            mem_rdata = (k == LAT) ? v.rdata : 16'hDEAD;
            @(posedge clk); #1;
        end
        mem_rdata = 16'hDEAD;
        if (!v.we) begin
            if (v.is_dma) exp_dma_rd = v.rdata;
            else          exp_cpu_rd = v.rdata;
        end
        chk_st($sformatf("v%0d state_recover", idx), ST_RECOVER);
        chk_b($sformatf("v%0d recover mem_en", idx), mem_en, 1'b0);
        chk_b($sformatf("v%0d recover cpu_r", idx), cpu_r, 1'b0);
        chk_b($sformatf("v%0d recover dma_ack", idx), dma_ack, 1'b0);
        chk_w($sformatf("v%0d cpu_rdata", idx), cpu_rdata, exp_cpu_rd);
        chk_w($sformatf("v%0d dma_rdata", idx), dma_rdata, exp_dma_rd);
        @(posedge clk); #1;
        chk_st($sformatf("v%0d state_idle", idx), ST_IDLE);
    endtask

    initial begin
        int pulses;
        int en_cycles;
        n_cmp  = 0;
        n_fail = 0;

        // {is_dma, we, size, addr, wdata, rdata, exp_addr, exp_be, exp_wdata}
        vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 16'hBEEF, 15'h1800, 2'b11, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h3001, 16'h12AB, 16'h0000, 15'h1800, 2'b10, 16'hABAB};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h4000, 16'h5634, 16'h0000, 15'h2000, 2'b01, 16'h3434};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h1235, 16'hCAFE, 16'h0000, 15'h091A, 2'b11, 16'hCAFE};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h1357, 15'h7FFF, 2'b10, 16'h0000};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h8000, 16'h0000, 16'hA5A5, 15'h4000, 2'b11, 16'h0000};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 16'h0002, 16'h7E81, 16'h0000, 15'h0001, 2'b11, 16'h7E81};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0000, 15'h0000, 2'b11, 16'hFFFF};

        // Reset state
        do_reset();
        chk_st("rst state", ST_IDLE);
        chk_b("rst mem_en", mem_en, 1'b0);
        chk_b("rst mem_we", mem_we, 1'b0);
        chk_w("rst mem_be", {14'b0, mem_be}, 16'h0000);
        chk_w("rst mem_addr", {1'b0, mem_addr}, 16'h0000);
        chk_w("rst mem_wdata", mem_wdata, 16'h0000);
        chk_b("rst cpu_r", cpu_r, 1'b0);
        chk_b("rst dma_ack", dma_ack, 1'b0);
        chk_w("rst cpu_rdata", cpu_rdata, 16'h0000);
        chk_w("rst dma_rdata", dma_rdata, 16'h0000);

        // Table of single accesses
        for (int i = 0; i < 8; i++) begin
            run_access(vecs[i], i);
        end

        // Both requesters held from reset: CPU, DMA, CPU, DMA
        do_reset();
        cpu_we = 1; cpu_size = 1; cpu_addr = 16'h0100; cpu_wdata = 16'h1111;
        dma_we = 1; dma_addr = 16'h0200; dma_wdata = 16'h2222;
        cpu_req = 1; dma_req = 1;
        for (int g = 0; g < 4; g++) begin
            @(posedge clk); #1;
            chk_b($sformatf("rr%0d mem_en", g), mem_en, 1'b1);
            chk_w($sformatf("rr%0d owner_addr", g), {1'b0, mem_addr},
                  ((g % 2) == 1) ? 16'h0100 : 16'h0080);
            repeat (LAT - 1) @(posedge clk);
            #1;
            chk_b($sformatf("rr%0d pulse", g), ((g % 2) == 1) ? dma_ack : cpu_r, 1'b1);
            @(posedge clk); #1;
            chk_st($sformatf("rr%0d recover", g), ST_RECOVER);
            @(posedge clk); #1;
            chk_st($sformatf("rr%0d idle", g), ST_IDLE);
            chk_b($sformatf("rr%0d idle mem_en", g), mem_en, 1'b0);
        end
        cpu_req = 0; dma_req = 0;

        // Reset two cycles into a DMA write aborts it
        do_reset();
        dma_we = 1; dma_addr = 16'h0400; dma_wdata = 16'h3333; dma_req = 1;
        @(posedge clk); #1;
        chk_w("abort dma addr", {1'b0, mem_addr}, 16'h0200);
        @(posedge clk); #1;
        chk_b("abort pre dma_ack", dma_ack, 1'b0);
        rst = 1;
        cpu_we = 1; cpu_size = 1; cpu_addr = 16'h0600; cpu_wdata = 16'h4444; cpu_req = 1;
        @(posedge clk); #1;
        chk_b("abort mem_en", mem_en, 1'b0);
        chk_b("abort dma_ack", dma_ack, 1'b0);
        chk_st("abort state", ST_IDLE);
        rst = 0;
        @(posedge clk); #1;
        chk_b("post-abort mem_en", mem_en, 1'b1);
        chk_w("post-abort grant cpu", {1'b0, mem_addr}, 16'h0300);
        cpu_req = 0; dma_req = 0;
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk_b("post-abort cpu_r", cpu_r, 1'b1);
        chk_b("post-abort dma_ack", dma_ack, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Last grant was CPU; reset must hand the next tie back to CPU
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        cpu_req = 1; dma_req = 1;
        @(posedge clk); #1;
        chk_w("rst last-grant tie", {1'b0, mem_addr}, 16'h0300);
        cpu_req = 0; dma_req = 0;
        repeat (LAT + 1) @(posedge clk);
        #1;
        chk_st("tie done idle", ST_IDLE);

        // CPU holds its request through RECOVER: one access, one pulse
        exp_cpu_rd = 16'h0000;
        cpu_we = 0; cpu_size = 1; cpu_addr = 16'h0020; cpu_wdata = 16'h0000;
        mem_rdata = 16'h4242;
        cpu_req = 1;
        pulses = 0;
        en_cycles = 0;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(posedge clk); #1;
            if (cpu_r) pulses++;
            if (mem_en) en_cycles++;
            if (c == LAT + 1) chk_st("hold recover", ST_RECOVER);
            if (c == LAT + 2) cpu_req = 0;
        end
        chk_w("hold pulse count", 16'(pulses), 16'd1);
        chk_w("hold access cycles", 16'(en_cycles), 16'(LAT));
        chk_w("hold cpu_rdata", cpu_rdata, 16'h4242);
        mem_rdata = 16'hDEAD;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 5, meaning cycles from grant to completion pulse (legal 2..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port cpu_req, input, 1, CPU memory request (microsequencer MIO_EN).
REQ-005 SHALL have port cpu_we, input, 1, 1=write, 0=read (R_W).
REQ-006 SHALL have port cpu_size, input, 1, 1=word, 0=byte (DATA_SIZE).
REQ-007 SHALL have port cpu_addr, input, 16, CPU byte address (MAR).
REQ-008 SHALL have port cpu_wdata, input, 16, CPU write data (MDR).
REQ-009 SHALL have port cpu_r, output, 1, CPU ready pulse (microsequencer r).
REQ-010 SHALL have port cpu_rdata, output, 16, CPU read word.
REQ-011 SHALL have ports dma_req, dma_we (inputs, 1), dma_addr, dma_wdata (inputs, 16), word-only DMA request.
REQ-012 SHALL have ports dma_ack (output, 1, completion pulse) and dma_rdata (output, 16).
REQ-013 SHALL have ports mem_en, mem_we (outputs, 1), mem_addr (output, 15, word address), mem_wdata (output, 16), mem_be (output, 2, byte enables).
REQ-014 SHALL have port mem_rdata, input, 16, memory read word, valid when the latency counter reaches 0.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RECOVER -> IDLE; ACCESS tagged with owner (CPU or DMA).
REQ-016 In IDLE, only one request pending SHALL grant it next cycle; both pending SHALL grant the owner not granted last (round-robin); first grant after reset goes to CPU.
REQ-017 At grant SHALL latch owner, we, size, addr and wdata; requester changes during ACCESS are ignored.
REQ-018 At grant SHALL load the down-counter with LATENCY-1; in ACCESS it decrements every cycle.
REQ-019 Throughout ACCESS SHALL drive mem_en=1, mem_we=latched we, mem_addr=latched addr[15:1]; outside ACCESS mem_en=mem_we=0.
REQ-020 Word access SHALL drive mem_be=11 and mem_wdata=wdata, ignoring addr[0].
REQ-021 Byte access SHALL drive mem_be=01 if addr[0]=0, 10 if addr[0]=1, and mem_wdata={wdata[7:0],wdata[7:0]}.
REQ-022 In the ACCESS cycle with counter=0 SHALL capture mem_rdata into the owner's rdata register (reads only) and pulse the owner's cpu_r or dma_ack for exactly one cycle, next state RECOVER.
REQ-023 cpu_rdata/dma_rdata SHALL hold their last captured value until the next read by that owner; byte extraction/sign extension is the datapath's job.
REQ-024 RECOVER SHALL last one cycle, grant nothing, and let the completed requester drop its request, so the same access is never issued twice.
REQ-025 A request dropped mid-ACCESS SHALL still complete and pulse its completion signal.
REQ-026 Total request-to-completion latency with no contention SHALL be LATENCY+1 cycles (grant cycle plus LATENCY).

Reset
REQ-027 While rst=1 at a clock edge SHALL enter IDLE, clear counter, set last-grant to DMA, and clear cpu_rdata/dma_rdata to 0.
REQ-028 After reset all outputs SHALL be 0: mem_en, mem_we, mem_be, mem_addr, mem_wdata, cpu_r, dma_ack.
REQ-029 Reset during ACCESS SHALL abort the access with no completion pulse; mem_en is low the following cycle.

Structure
REQ-030 Package lc3b_mem_pkg SHALL hold the FSM state enum, owner encoding, BE constants (BE_WORD=11, BE_LO=01, BE_HI=10) and default LATENCY.
REQ-031 Round-robin choice SHALL be a separate sub-module rr_arb2 (2 requests, last-grant in, one-hot grant out); everything else is in mem_arbiter.

Verification
REQ-032 CPU word read addr 0x3000, mem_rdata=0xBEEF at counter 0, LATENCY=5 -> cpu_r pulses 6 cycles after cpu_req, cpu_rdata=0xBEEF, mem_addr=0x1800, mem_be=11.
REQ-033 CPU byte write addr 0x3001, wdata 0x12AB -> mem_be=10, mem_wdata=0xABAB, mem_we=1 for 5 cycles, cpu_r pulses once.
REQ-034 cpu_req and dma_req both raised from reset and held -> CPU, DMA, CPU, DMA grants in order, one RECOVER cycle between each.
REQ-035 rst asserted 2 cycles into a DMA write -> no dma_ack, mem_en=0 next cycle, next grant after reset is CPU.
REQ-036 CPU holds cpu_req 1 cycle past cpu_r (into RECOVER), then drops -> exactly one access issued, single cpu_r pulse.
REQ-037 cpu_addr changed mid-ACCESS -> mem_addr unchanged until completion.
